// File: rtl/uart_transmitter_if.sv
// Parallel word handshake between a producer and uart_transmitter.
// The producer drives data/data_valid; the transmitter answers with ready.
interface uart_transmitter_if #(
  parameter int unsigned MAX_LEN = 9
) ();

  logic [MAX_LEN-1:0] data;
  logic               data_valid;
  logic               ready;

  modport master (
    output data,
    output data_valid,
    input  ready
  );

  modport slave (
    input  data,
    input  data_valid,
    output ready
  );

endinterface

// File: rtl/uart_transmitter.sv
// Serial UART transmitter clocked by the 16x baud clock.
// Frame: start bit, 5..9 data bits (LSB first), optional even/odd parity,
// one or two stop bits. Every serial bit is held for OVERSAMPLE clocks.
module uart_transmitter #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned MAX_LEN    = 9
) (
  input  logic                 clk_16bd,
  input  logic                 rst,
  uart_transmitter_if.slave    host,
  input  logic                 parity,
  input  logic                 parity_type,
  input  logic                 stop_bits,
  input  logic [3:0]           frame_length,
  output logic                 Tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned TICK_W  = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [3:0] MIN_BITS = 4'd5;
  localparam logic [3:0] MAX_BITS = 4'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [TICK_W-1:0]    tick;
  logic [3:0]           bit_cnt;
  logic [3:0]           len_q;
  logic [MAX_LEN-1:0]   shift;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 two_stop_q;
  logic                 stop_cnt;
  logic                 tx_q;
  logic                 busy_q;
  logic                 ready_q;
  logic                 done_q;

  logic [3:0]           eff_len;
  logic [MAX_LEN-1:0]   masked;
  logic                 par_calc;
  logic                 tick_wrap;

  assign tick_wrap  = (tick == TICK_LAST);
  assign Tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;
  assign host.ready = ready_q;

  // Clamp the requested length, drop data bits beyond it and precompute parity.
  always_comb begin
    eff_len = frame_length;
    if (frame_length < MIN_BITS)
      eff_len = MIN_BITS;
    else if (frame_length > MAX_BITS)
      eff_len = MAX_BITS;
    masked = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++)
      masked[i] = host.data[i] & (i < 32'(eff_len));
    par_calc = (^masked) ^ parity_type;
  end

  // Frame sequencer: all outputs registered, transitions only on tick wrap.
  always_ff @(posedge clk_16bd or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      len_q      <= '0;
      shift      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop_cnt   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (state != IDLE)
        tick <= tick_wrap ? '0 : tick + 1'b1;

      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          tick <= '0;
          if (host.data_valid && ready_q) begin
            state      <= START;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            shift      <= masked;
            len_q      <= eff_len;
            par_en_q   <= parity;
            par_bit_q  <= par_calc;
            two_stop_q <= stop_bits;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
          end
        end

        START: begin
          if (tick_wrap) begin
            state <= DATA;
            tx_q  <= shift[0];
          end
        end

        // The next data bit is shift[1] because the shift lands on this same edge.
        DATA: begin
          if (tick_wrap) begin
            shift <= {1'b0, shift[MAX_LEN-1:1]};
            if (bit_cnt == len_q - 4'd1) begin
              bit_cnt <= '0;
              if (par_en_q) begin
                state <= PARITY;
                tx_q  <= par_bit_q;
              end else begin
                state <= STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              tx_q    <= shift[1];
            end
          end
        end

        PARITY: begin
          if (tick_wrap) begin
            state <= STOP;
            tx_q  <= 1'b1;
          end
        end

        STOP: begin
          if (tick_wrap) begin
            if (two_stop_q && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              stop_cnt <= 1'b0;
              state    <= IDLE;
              busy_q   <= 1'b0;
              ready_q  <= 1'b1;
              done_q   <= 1'b1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: table of hand-computed frames
// plus directed sequences for back-to-back, ignored request and reset abort.
module tb_uart_transmitter;

  logic       clk_16bd;
  logic       rst;
  logic       parity;
  logic       parity_type;
  logic       stop_bits;
  logic [3:0] frame_length;
  logic       Tx;
  logic       busy;
  logic       tx_done;

  int unsigned checks;
  int unsigned errors;

  uart_transmitter_if #(.MAX_LEN(9)) host_if ();

  uart_transmitter #(
    .OVERSAMPLE(16),
    .MAX_LEN(9)
  ) dut (
    .clk_16bd    (clk_16bd),
    .rst         (rst),
    .host        (host_if.slave),
    .parity      (parity),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .frame_length(frame_length),
    .Tx          (Tx),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  initial clk_16bd = 1'b0;
  always #5 clk_16bd = ~clk_16bd;

  typedef struct {
    string       name;
    logic [8:0]  data;
    logic [3:0]  fl;
    logic        par;
    logic        ptype;
    logic        stop2;
    string       bits;    // line level per serial bit, in transmit order
    int unsigned cycles;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_16bd);
    #1;
  endtask

  task automatic wait_ready();
    int unsigned n;
    n = 0;
    while (host_if.ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (host_if.ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: ready never rose within 300 cycles");
    end
  endtask

  task automatic drive(input vec_t v);
    host_if.data = v.data;
    frame_length = v.fl;
    parity       = v.par;
    parity_type  = v.ptype;
    stop_bits    = v.stop2;
  endtask

  // Entered #1 after the capture edge; leaves #1 after the edge ending the frame.
  task automatic check_frame(input vec_t v);
    logic exp_bit;
    for (int unsigned c = 0; c < v.cycles; c++) begin
      if (c == 0) begin
        chk({v.name, "_tx_start"}, 32'(Tx), 32'd0);
        chk({v.name, "_busy"}, 32'(busy), 32'd1);
        chk({v.name, "_ready_low"}, 32'(host_if.ready), 32'd0);
      end
      if (c % 16 == 8) begin
        exp_bit = (v.bits.getc(int'(c / 16)) == 8'h31);
        chk($sformatf("%s_bit%0d", v.name, c / 16), 32'(Tx), 32'(exp_bit));
      end
      if (c == v.cycles - 1)
        chk({v.name, "_busy_last"}, 32'(busy), 32'd1);
      tick();
    end
    chk({v.name, "_done"}, 32'(tx_done), 32'd1);
    chk({v.name, "_ready_end"}, 32'(host_if.ready), 32'd1);
    chk({v.name, "_busy_end"}, 32'(busy), 32'd0);
    chk({v.name, "_tx_idle"}, 32'(Tx), 32'd1);
  endtask

  // Capture the word, then scramble every input to show it was latched.
  task automatic send(input vec_t v);
    wait_ready();
    drive(v);
    host_if.data_valid = 1'b1;
    tick();
    host_if.data_valid = 1'b0;
    host_if.data = ~v.data;
    frame_length = 4'd7;
    parity       = ~v.par;
    parity_type  = ~v.ptype;
    stop_bits    = ~v.stop2;
    check_frame(v);
    tick();
    chk({v.name, "_done_pulse"}, 32'(tx_done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    host_if.data = '0;
    host_if.data_valid = 1'b0;
    parity = 1'b0;
    parity_type = 1'b0;
    stop_bits = 1'b0;
    frame_length = 4'd8;

    vecs[0] = '{"e8_65",  9'h065, 4'd8,  1'b1, 1'b0, 1'b0, "01010011001",  176};
    vecs[1] = '{"e8_47",  9'h047, 4'd8,  1'b1, 1'b0, 1'b0, "01110001001",  176};
    vecs[2] = '{"o8_2s",  9'h065, 4'd8,  1'b1, 1'b1, 1'b1, "010100110111", 192};
    vecs[3] = '{"n5_1ff", 9'h1FF, 4'd5,  1'b0, 1'b0, 1'b0, "0111111",      112};
    vecs[4] = '{"fl15",   9'h155, 4'd15, 1'b1, 1'b0, 1'b0, "010101010111", 192};
    vecs[5] = '{"fl2",    9'h0E3, 4'd2,  1'b1, 1'b1, 1'b0, "01100011",     128};

    repeat (3) tick();
    chk("rst_tx", 32'(Tx), 32'd1);
    chk("rst_ready", 32'(host_if.ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++)
      send(vecs[i]);

    // Back-to-back: data_valid held high, next word captured in the tx_done cycle.
    repeat (3) tick();
    drive(vecs[0]);
    host_if.data_valid = 1'b1;
    tick();
    host_if.data = 9'h047;
    check_frame(vecs[0]);
    tick();
    host_if.data_valid = 1'b0;
    check_frame(vecs[1]);
    tick();
    chk("b2b_done_pulse", 32'(tx_done), 32'd0);

    // Request while busy is dropped, not queued.
    repeat (3) tick();
    drive(vecs[0]);
    host_if.data_valid = 1'b1;
    tick();
    host_if.data_valid = 1'b0;
    fork
      check_frame(vecs[0]);
      begin
        repeat (40) tick();
        host_if.data = 9'h0AA;
        host_if.data_valid = 1'b1;
        tick();
        host_if.data_valid = 1'b0;
      end
    join
    repeat (40) tick();
    chk("ign_tx_idle", 32'(Tx), 32'd1);
    chk("ign_busy", 32'(busy), 32'd0);
    chk("ign_ready", 32'(host_if.ready), 32'd1);

    // Reset during data bit 3 aborts the frame asynchronously.
    drive(vecs[0]);
    host_if.data_valid = 1'b1;
    tick();
    host_if.data_valid = 1'b0;
    repeat (70) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_tx", 32'(Tx), 32'd1);
    chk("arst_ready", 32'(host_if.ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    send(vecs[3]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
